// File: rtl/exam_sched_pkg.sv
// Shared types for the time-shared ALU scheduler.
package exam_sched_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  typedef enum logic [OP_W-1:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    AND    = 3'd2,
    OR     = 3'd3,
    XOR    = 3'd4,
    PASS_A = 3'd5
  } alu_op_t;

endpackage

// File: rtl/exam_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module exam_rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand[IW-1:0]]) begin
        any                = 1'b1;
        grant[cand[IW-1:0]] = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/exam_alu_sched.sv
// Round-robin scheduler sharing one registered ALU between N requesters.
module exam_alu_sched
  import exam_sched_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 8,
  parameter int unsigned N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*W-1:0]    req_a,
  input  logic [N*W-1:0]    req_b,
  input  logic [N*OP_W-1:0] req_op,
  output logic [N-1:0]      res_valid,
  input  logic [N-1:0]      res_ready,
  output logic [W-1:0]      res_data,
  output logic              res_flag,
  output logic              res_err,
  output logic [CW-1:0]     op_count,
  output logic              busy
);

  localparam int unsigned IW = $clog2(N);

  sched_state_t    state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    res_valid_q, res_valid_d;
  logic [W-1:0]    res_data_q, res_data_d;
  logic            res_flag_q, res_flag_d;
  logic            res_err_q, res_err_d;
  logic [CW-1:0]   op_count_q, op_count_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  exam_rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // ALU result packed as {err, flag, data}.
  function automatic logic [W+1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [OP_W-1:0] op);
    logic [W:0]   sum;
    logic [W-1:0] data;
    logic         flag;
    logic         err;
    sum  = '0;
    data = '0;
    flag = 1'b0;
    err  = 1'b0;
    case (op)
      ADD: begin
        sum  = {1'b0, a} + {1'b0, b};
        data = sum[W-1:0];
        flag = sum[W];
      end
      SUB: begin
        data = a - b;
        flag = (a < b);
      end
      AND:     data = a & b;
      OR:      data = a | b;
      XOR:     data = a ^ b;
      PASS_A:  data = a;
      default: err = 1'b1;
    endcase
    return {err, flag, data};
  endfunction

  // Next-state logic: grant in IDLE, compute in EXEC, hold result until consumed in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    grant_d     = grant_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flag_d  = res_flag_q;
    res_err_d   = res_err_q;
    op_count_d  = op_count_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = arb_grant;
        if (arb_any) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (arb_grant[i]) begin
              a_d  = req_a[i*W +: W];
              b_d  = req_b[i*W +: W];
              op_d = req_op[i*OP_W +: OP_W];
            end
          end
          grant_d = arb_grant;
          ptr_d   = (32'(arb_idx) == N - 1) ? '0 : arb_idx + IW'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        {res_err_d, res_flag_d, res_data_d} = alu(a_q, b_q, op_q);
        res_valid_d = grant_q;
        state_d     = RESP;
      end
      RESP: begin
        // Only the owning requester's res_ready bit can complete the operation.
        if (|(res_valid_q & res_ready)) begin
          res_valid_d = '0;
          op_count_d  = op_count_q + CW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      grant_q     <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_flag_q  <= 1'b0;
      res_err_q   <= 1'b0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      grant_q     <= grant_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flag_q  <= res_flag_d;
      res_err_q   <= res_err_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flag  = res_flag_q;
  assign res_err   = res_err_q;
  assign op_count  = op_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_exam_alu_sched.sv
// Scoreboard bench for exam_alu_sched.
`timescale 1ns/1ps
module tb_exam_alu_sched;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, res_valid, res_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0]   res_data;
  logic           res_flag, res_err, busy;
  logic [CW-1:0]  op_count;

  exam_alu_sched #(.W(W), .CW(CW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flag  (res_flag),
    .res_err   (res_err),
    .op_count  (op_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       flag;
    logic       err;
    int         acc;
    bit         seen;
  } exp_t;

  exp_t       sb[$];
  int         glog[$];
  int         n_chk = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         total = 0;
  int         mptr = 0;
  logic [7:0] mcnt = '0;
  bit         rnd_rr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU in integer arithmetic: {err, flag, data}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int r, ai, bi;
    logic f, e;
    ai = int'(a); bi = int'(b); r = 0; f = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin r = ai + bi; f = (r > 255); end
      3'd1: begin r = ai - bi; f = (r < 0); if (r < 0) r = r + 256; end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: r = ai;
      default: e = 1'b1;
    endcase
    return {e, f, 8'(r)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & 3'b001) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  // Monitor: model accepts, compare results, track consumed-op count.
  always @(negedge clk) begin
    exp_t       e;
    int         g;
    logic [9:0] m;
    logic [N-1:0] hs;
    cyc++;
    if (rst) begin
      sb.delete();
      mptr  = 0;
      mcnt  = '0;
      total = 0;
    end else begin
      check("op_count", 32'(op_count), 32'(mcnt));
      check("ready_no_req", 32'(req_ready & ~req_valid), 0);
      if (busy) check("ready_busy", 32'(req_ready), 0);
      if (res_valid != 0) begin
        if (sb.size() == 0) begin
          check("res_unexpected", 32'(res_valid), 0);
        end else begin
          e = sb[0];
          if (!e.seen) begin
            check("latency", cyc - e.acc, 2);
            sb[0].seen = 1'b1;
          end
          check("res_valid", 32'(res_valid), 32'(1) << e.idx);
          check("res_data", 32'(res_data), 32'(e.data));
          check("res_flag", 32'(res_flag), 32'(e.flag));
          check("res_err", 32'(res_err), 32'(e.err));
          check("busy_resp", 32'(busy), 1);
          if (((res_ready >> e.idx) & 3'b001) != 0) begin
            void'(sb.pop_front());
            mcnt++;
            total++;
          end
        end
      end
      hs = req_valid & req_ready;
      if (!busy && req_valid != 0) check("grant_missing", 32'(hs != 0), 1);
      if (hs != 0) begin
        g = rr_pick(req_valid, mptr);
        check("grant", 32'(req_ready), 32'(1) << g);
        m = model(8'(req_a >> (g * W)), 8'(req_b >> (g * W)), 3'(req_op >> (g * 3)));
        sb.push_back('{idx: g, data: m[7:0], flag: m[8], err: m[9], acc: cyc, seen: 1'b0});
        glog.push_back(g);
        mptr = (g + 1) % N;
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rr) res_ready = 3'($urandom);
  endtask

  task automatic wait_grant(input int i);
    int t;
    t = 0;
    #1;
    while (((req_ready >> i) & 3'b001) == 0 && t < 60) begin
      tick();
      t++;
    end
    if (t >= 60) check("grant_timeout", 0, 1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
    req_valid[i]     = 1'b1;
    wait_grant(i);
  endtask

  task automatic wait_res(input int i);
    int t;
    t = 0;
    while (((res_valid >> i) & 3'b001) == 0 && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) check("res_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 80) begin
      tick();
      t++;
    end
    if (t >= 80) check("drain_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] d;
    logic       f;
  } vec_t;

  vec_t       vecs[3];
  int         base_n, base_g;
  int         t;
  logic [7:0] cap;
  logic [7:0] cnt0;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; res_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_flag", 32'(res_flag), 0);
    check("rst_res_err", 32'(res_err), 0);
    check("rst_req_ready", 32'(req_ready), 0);

    // Single request with delayed consume.
    res_ready = 3'b000;
    do_op(0, 8'h01, 8'h03, 3'd0);
    wait_res(0);
    check("single_data", 32'(res_data), 32'h04);
    check("single_flag", 32'(res_flag), 0);
    res_ready = 3'b001;
    tick();
    check("single_count", 32'(op_count), 1);
    res_ready = 3'b111;

    // Carry / borrow.
    vecs[0] = '{a: 8'hFF, b: 8'h02, op: 3'd0, d: 8'h01, f: 1'b1};
    vecs[1] = '{a: 8'h02, b: 8'h05, op: 3'd1, d: 8'hFD, f: 1'b1};
    vecs[2] = '{a: 8'h07, b: 8'h01, op: 3'd1, d: 8'h06, f: 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_op(1, vecs[k].a, vecs[k].b, vecs[k].op);
      wait_res(1);
      check("cb_data", 32'(res_data), 32'(vecs[k].d));
      check("cb_flag", 32'(res_flag), 32'(vecs[k].f));
      drain();
    end

    // Fairness under full contention from pointer 0.
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = 24'h302010; req_b = 24'h030201; req_op = {3'd4, 3'd1, 3'd0};
    base_n = n_acc; base_g = glog.size();
    req_valid = 3'b111;
    t = 0;
    while (n_acc < base_n + 9 && t < 100) begin tick(); t++; end
    req_valid = '0;
    if (t >= 100) check("rr_timeout", 0, 1);
    drain();
    for (int k = 0; k < 9; k++) begin
      if (base_g + k < glog.size()) check("rr_order", glog[base_g + k], k % 3);
      else check("rr_short", 0, 1);
    end

    // Backpressure on requester 1 while requester 0 waits.
    res_ready = 3'b101;
    do_op(1, 8'h5A, 8'h0F, 3'd2);
    wait_res(1);
    cap  = res_data;
    cnt0 = op_count;
    check("bp_data", 32'(cap), 32'h0A);
    req_a[7:0] = 8'h33; req_b[7:0] = 8'h44; req_op[2:0] = 3'd5;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 32'(res_valid), 32'h2);
      check("bp_hold", 32'(res_data), 32'(cap));
      check("bp_ready", 32'(req_ready), 0);
      check("bp_busy", 32'(busy), 1);
      check("bp_count", 32'(op_count), 32'(cnt0));
      tick();
    end
    res_ready = 3'b111;
    tick();
    check("bp_release", 32'(op_count), 32'(8'(cnt0 + 8'd1)));
    wait_grant(0);
    drain();

    // Illegal opcode, then a legal XOR.
    do_op(2, 8'h12, 8'h34, 3'd6);
    wait_res(2);
    check("ill_err", 32'(res_err), 1);
    check("ill_data", 32'(res_data), 0);
    check("ill_flag", 32'(res_flag), 0);
    drain();
    do_op(2, 8'h0F, 8'h05, 3'd4);
    wait_res(2);
    check("xor_data", 32'(res_data), 32'h0A);
    check("xor_err", 32'(res_err), 0);
    drain();

    // Reset while in EXEC.
    do_op(0, 8'h11, 8'h22, 3'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_res_valid", 32'(res_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_count", 32'(op_count), 0);
    req_valid = 3'b111;
    #1;
    check("mid_first", 32'(req_ready), 32'h1);
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    drain();

    // Random traffic with random backpressure until the counter wraps.
    rnd_rr = 1'b1;
    for (int it = 0; it < 320 && total < 262; it++) begin
      do_op(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    end
    rnd_rr = 1'b0;
    res_ready = 3'b111;
    drain();
    check("wrap_reached", 32'(total >= 256), 1);
    check("wrap_count", 32'(op_count), 32'(8'(total)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
